alu_seq: RTL and testbench

//  Sequential, handshaked ALU: next generation of the CPU's combinational ALU.

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle ADD/SHR/SHL/XRD/SUB/AND/OR plus an
// iterative shift-add MUL, with registered result and Zero/Sign/Carry flags.
module alu_seq #(
    parameter int W      = 8,
    parameter int OPW    = 4,
    parameter int MUL_EN = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [OPW-1:0] OP,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out,
    output logic           Zero,
    output logic           Sign,
    output logic           Carry
);

    localparam int CW = $clog2(W);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SHR = OPW'(1);
    localparam logic [OPW-1:0] OP_SHL = OPW'(2);
    localparam logic [OPW-1:0] OP_XRD = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4);
    localparam logic [OPW-1:0] OP_AND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);
    localparam logic [OPW-1:0] OP_MUL = OPW'(7);

    localparam logic [W:0]    SHIFT_LIMIT = (W+1)'(W);
    localparam logic [CW-1:0] CNT_LAST    = CW'(W-1);

    typedef enum logic [1:0] {
        IDLE,
        MULB,
        DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
    } alu_res_t;

    // Single-cycle datapath; MUL (when enabled) never reaches here, so opcode 7
    // falls into the default and yields 0 when MUL_EN is 0.
    function automatic alu_res_t alu_eval(input logic [W-1:0]   a,
                                          input logic [W-1:0]   b,
                                          input logic [OPW-1:0] op);
        alu_res_t   r;
        logic [W:0] sum;
        logic       big_shift;
        r         = '0;
        sum       = {1'b0, a} + {1'b0, b};
        big_shift = ({1'b0, b} >= SHIFT_LIMIT);
        case (op)
            OP_ADD: begin
                r.res   = sum[W-1:0];
                r.carry = sum[W];
            end
            OP_SHR:  r.res = big_shift ? '0 : (a >> b);
            OP_SHL:  r.res = big_shift ? '0 : (a << b);
            OP_XRD:  r.res = {{(W-1){1'b0}}, ^a};
            OP_SUB: begin
                r.res   = a - b;
                r.carry = (a < b);
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          zero_q, zero_d;
    logic          sign_q, sign_d;
    logic          carry_q, carry_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    alu_res_t      ev;
    logic          is_mul;
    logic [W-1:0]  mul_sum;
    logic          res_load;
    logic [W-1:0]  res_val;
    logic          res_carry;

    assign ev      = alu_eval(A, B, OP);
    assign is_mul  = (MUL_EN != 0) && (OP == OP_MUL);
    assign mul_sum = b_q[0] ? (acc_q + a_q) : acc_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (an unassigned path in combinational logic infers a latch).
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        res_load    = 1'b0;
        res_val     = '0;
        res_carry   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (is_mul) begin
                        a_d     = A;
                        b_d     = B;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MULB;
                    end else begin
                        res_load  = 1'b1;
                        res_val   = ev.res;
                        res_carry = ev.carry;
                        state_d   = DONE;
                    end
                end
            end
            MULB: begin
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                acc_d = mul_sum;
                cnt_d = cnt_q + 1'b1;
                // The last partial product is folded straight into the result.
                if (cnt_q == CNT_LAST) begin
                    res_load = 1'b1;
                    res_val  = mul_sum;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (res_load) begin
            out_d       = res_val;
            zero_d      = (res_val == '0);
            sign_d      = res_val[W-1];
            carry_d     = res_carry;
            out_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign Zero      = zero_q;
    assign Sign      = sign_q;
    assign Carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level reference model compared
// every cycle, directed cases with hand-computed results, then random traffic.
module tb_alu_seq;

    localparam int W      = 8;
    localparam int OPW    = 4;
    localparam int MUL_EN = 1;

    logic           Clk       = 1'b0;
    logic           Reset     = 1'b1;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   A         = '0;
    logic [W-1:0]   B         = '0;
    logic [OPW-1:0] OP        = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out;
    logic           Zero;
    logic           Sign;
    logic           Carry;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit cmp_en = 1'b0;

    logic [W-1:0] last_out;
    logic         last_z;
    logic         last_s;
    logic         last_c;

    alu_seq #(.W(W), .OPW(OPW), .MUL_EN(MUL_EN)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Zero      (Zero),
        .Sign      (Sign),
        .Carry     (Carry)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode table.
    function automatic void ref_eval(input int a, input int b, input int op,
                                     output int res, output bit c);
        int mask;
        mask = (1 << W) - 1;
        res  = 0;
        c    = 1'b0;
        case (op)
            0: begin res = (a + b) & mask; c = ((a + b) >> W) != 0; end
            1: res = (b >= W) ? 0 : (a >> b);
            2: res = (b >= W) ? 0 : ((a << b) & mask);
            3: res = $countones(a) & 1;
            4: begin res = (a - b) & mask; c = (a < b); end
            5: res = a & b;
            6: res = a | b;
            7: res = (MUL_EN != 0) ? ((a * b) & mask) : 0;
            default: res = 0;
        endcase
    endfunction

    // Transaction model: idle (0), multiply in progress (1), result held (2).
    int           m_phase = 0;
    int           m_left  = 0;
    int           p_res   = 0;
    bit           p_c     = 1'b0;
    logic [W-1:0] m_out   = '0;
    bit           m_z     = 1'b0;
    bit           m_s     = 1'b0;
    bit           m_c     = 1'b0;

    always @(posedge Clk or posedge Reset) begin : model
        int r;
        bit c;
        if (Reset) begin
            m_phase = 0;
            m_out   = '0;
            m_z     = 1'b0;
            m_s     = 1'b0;
            m_c     = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    ref_eval(int'(A), int'(B), int'(OP), r, c);
                    if (MUL_EN != 0 && int'(OP) == 7) begin
                        m_phase = 1;
                        m_left  = W;
                        p_res   = r;
                        p_c     = c;
                    end else begin
                        m_out   = W'(r);
                        m_z     = (r == 0);
                        m_s     = m_out[W-1];
                        m_c     = c;
                        m_phase = 2;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_out   = W'(p_res);
                        m_z     = (p_res == 0);
                        m_s     = m_out[W-1];
                        m_c     = p_c;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("in_ready",  in_ready,  m_phase == 0);
            check("out_valid", out_valid, m_phase == 2);
            check("out",       out,       m_out);
            check("zero",      Zero,      m_z);
            check("sign",      Sign,      m_s);
            check("carry",     Carry,     m_c);
        end
    end

    // Issue one operation, wait for its result, hold it `stall` cycles, retire.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OPW-1:0] op, input int stall, output int lat);
        int g;
        @(negedge Clk);
        A = a; B = b; OP = op; in_valid = 1'b1; out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge Clk);
            g++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        A  = W'($urandom);
        B  = W'($urandom);
        OP = OPW'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge Clk);
            lat++;
            in_valid = 1'($urandom_range(0, 1));
        end
        check("result_arrived", out_valid, 1);
        last_out = out;
        last_z   = Zero;
        last_s   = Sign;
        last_c   = Carry;
        repeat (stall) begin
            @(negedge Clk);
            in_valid = 1'($urandom_range(0, 1));
            A = W'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        check("retire_in_ready",  in_ready,  1);
        check("retire_out_valid", out_valid, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        repeat (3) @(negedge Clk);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_flags",     {Zero, Sign, Carry}, 0);
        Reset  = 1'b0;
        cmp_en = 1'b1;

        do_op(8'hF0, 8'h20, 4'd0, 0, lat);
        check("add_lat", lat, 1);
        check("add_out", last_out, 8'h10);
        check("add_zsc", {last_z, last_s, last_c}, 3'b001);

        do_op(8'h05, 8'h05, 4'd4, 0, lat);
        check("sub_eq_out", last_out, 8'h00);
        check("sub_eq_zsc", {last_z, last_s, last_c}, 3'b100);
        do_op(8'h03, 8'h05, 4'd4, 0, lat);
        check("sub_lt_out", last_out, 8'hFE);
        check("sub_lt_zsc", {last_z, last_s, last_c}, 3'b011);

        do_op(8'h01, 8'd9, 4'd2, 0, lat);
        check("shl_big_out", last_out, 8'h00);
        check("shl_big_z",   last_z,   1);
        do_op(8'h80, 8'd7, 4'd1, 0, lat);
        check("shr_out", last_out, 8'h01);
        do_op(8'h07, 8'h00, 4'd3, 0, lat);
        check("xrd_out", last_out, 8'h01);
        do_op(8'h5A, 8'h3C, 4'd11, 0, lat);
        check("undef_out", last_out, 8'h00);

        do_op(8'h33, 8'h0F, 4'd6, 5, lat);
        check("or_stall_out", last_out, 8'h3F);

        do_op(8'd13, 8'd11, 4'd7, 0, lat);
        check("mul_lat", lat, W + 1);
        check("mul_out", last_out, 8'h8F);
        check("mul_zsc", {last_z, last_s, last_c}, 3'b010);
        do_op(8'd16, 8'd16, 4'd7, 0, lat);
        check("mul_wrap_out", last_out, 8'h00);
        check("mul_wrap_z",   last_z,   1);

        @(negedge Clk);
        A = 8'd13; B = 8'd11; OP = 4'd7; in_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("mul_busy", in_ready, 0);
        #2 Reset = 1'b1;
        #1;
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out",       out,       0);
        check("midrst_flags",     {Zero, Sign, Carry}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        do_op(8'd1, 8'd1, 4'd0, 0, lat);
        check("post_rst_add", last_out, 8'h02);

        repeat (3000) begin
            @(negedge Clk);
            in_valid  = 1'($urandom_range(0, 1));
            A         = W'($urandom);
            B         = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
            OP        = ($urandom_range(0, 3) == 0) ? OPW'($urandom_range(8, 15))
                                                    : OPW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
